// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count and status flags.
//
// Ports:
//   clk          - rising-edge clock, sole clock domain
//   reset        - synchronous active-low reset (0 = reset)
//   wr           - write request; w_data pushed when not full (or when full and popping)
//   w_data       - write data
//   rd           - read request; head word popped when not empty
//   r_data       - current head word, valid whenever empty == 0
//   empty        - count == 0
//   full         - count == DEPTH
//   almost_empty - count <= 1
//   almost_full  - count >= DEPTH-1
//   word_count   - number of stored words, 0..DEPTH
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH+1:0] word_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CntDepth    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CntDepthM1  = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CntOne      = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_do_wr;
  logic                  w_do_rd;
  logic [ADDR_WIDTH:0]   w_count_d;

  // When full, a simultaneous pop frees the slot, so the write is still accepted.
  // When empty, a simultaneous read is ignored and only the write happens.
  always_comb begin
    w_do_rd = rd & ~empty;
    w_do_wr = wr & (~full | rd);
  end

  always_comb begin
    w_count_d = r_count;
    unique case ({w_do_wr, w_do_rd})
      2'b10:   w_count_d = r_count + CntOne;
      2'b01:   w_count_d = r_count - CntOne;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_d;
    end
  end

  // Storage is never cleared; reset only invalidates it through the pointers and count.
  // When full with a simultaneous pop, wr_ptr == rd_ptr: the old head is read out
  // combinationally before this edge overwrites that slot.
  always_ff @(posedge clk) begin
    if (reset && w_do_wr) r_mem[r_wr_ptr] <= w_data;
  end

  always_comb begin
    r_data       = r_mem[r_rd_ptr];
    empty        = (r_count == '0);
    full         = (r_count == CntDepth);
    almost_empty = (r_count <= CntOne);
    almost_full  = (r_count >= CntDepthM1);
    word_count   = {1'b0, r_count};
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DATA_WIDTH=4, ADDR_WIDTH=4, DEPTH=16).
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [3:0] w_data;
  logic       rd;
  logic [3:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [5:0] word_count;

  int n_total;
  int n_bad;

  logic [3:0] exp_q [$];
  logic [3:0] exp_v;

  sync_fifo #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(4)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .word_count  (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input int cnt);
    check_eq({tag, ".count"}, 32'(word_count), 32'(cnt));
    check_eq({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    check_eq({tag, ".full"}, 32'(full), 32'(cnt == 16));
    check_eq({tag, ".aempty"}, 32'(almost_empty), 32'(cnt <= 1));
    check_eq({tag, ".afull"}, 32'(almost_full), 32'(cnt >= 15));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    w_data  = '0;
    #1;

    // Reset
    step();
    check_flags("reset", 0);
    reset = 1'b1;

    // Fill 0..15
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1;
      w_data = 4'(i);
      step();
      check_flags("fill", i + 1);
      check_eq("fill.rdata", 32'(r_data), 32'd0);
    end

    // Overflow attempts
    for (int i = 0; i < 2; i++) begin
      w_data = 4'hF;
      step();
      check_flags("ovf", 16);
      check_eq("ovf.rdata", 32'(r_data), 32'd0);
    end
    wr = 1'b0;

    // Drain
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("drain.rdata", 32'(r_data), 32'(i));
      step();
      check_flags("drain", 15 - i);
    end
    step();
    check_flags("udf", 0);
    rd = 1'b0;

    // Refill, then simultaneous rd/wr while full
    wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_data = 4'(i);
      step();
    end
    check_flags("refill", 16);
    rd = 1'b1;
    w_data = 4'hA;
    check_eq("simfull.head0", 32'(r_data), 32'd0);
    step();
    check_flags("simfull", 16);
    check_eq("simfull.head1", 32'(r_data), 32'd1);
    wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_eq("simdrain.rdata", 32'(r_data), (i < 15) ? 32'(i + 1) : 32'hA);
      step();
    end
    check_flags("simdrain", 0);

    // Simultaneous rd/wr while empty: write only
    wr = 1'b1;
    w_data = 4'hA;
    step();
    check_flags("simempty", 1);
    check_eq("simempty.rdata", 32'(r_data), 32'hA);
    wr = 1'b0;
    step();
    check_flags("simempty.pop", 0);
    rd = 1'b0;

    // Wrap: write 10, read 8, write 12, read 6 (pointers start at 2)
    wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w_data = 4'(i + 5);
      exp_q.push_back(4'(i + 5));
      step();
    end
    wr = 1'b0;
    rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_v = exp_q.pop_front();
      check_eq("wrap.rd1", 32'(r_data), 32'(exp_v));
      step();
    end
    rd = 1'b0;
    wr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      w_data = 4'(i * 3);
      exp_q.push_back(4'(i * 3));
      step();
    end
    wr = 1'b0;
    check_flags("wrap.mid", 14);
    rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_v = exp_q.pop_front();
      check_eq("wrap.rd2", 32'(r_data), 32'(exp_v));
      step();
    end
    rd = 1'b0;
    check_flags("wrap.end", 8);

    // Reset mid-operation, with rd/wr asserted to confirm reset wins
    reset = 1'b0;
    wr = 1'b1;
    rd = 1'b1;
    step();
    check_flags("midreset", 0);
    reset = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    step();
    check_flags("postreset", 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
